// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared FSM encoding and default widths for the truth-table sweep controller
package tt_sweep_pkg;
   localparam int DEF_IN_W   = 8;
   localparam int DEF_OUT_W  = 5;
   localparam int DEF_SETTLE = 1;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/tt_err_log.sv
// tt_err_log: compares two implementation outputs, counts mismatches, captures the first failing vector
// ports: clk/rst; clr restarts the log for a new sweep; chk marks the sampling cycle;
//        x/y_a/y_b are the vector and both outputs; mismatch is the live compare result;
//        err_count and first_err_* hold the sweep's error record
module tt_err_log
   import tt_sweep_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             chk,
   input  logic [IN_W-1:0]  x,
   input  logic [OUT_W-1:0] y_a,
   input  logic [OUT_W-1:0] y_b,
   output logic             mismatch,
   output logic [IN_W:0]    err_count,
   output logic             first_err_valid,
   output logic [IN_W-1:0]  first_err_x,
   output logic [OUT_W-1:0] first_err_ya,
   output logic [OUT_W-1:0] first_err_yb
);
   assign mismatch = y_a != y_b;
   // err_count is one bit wider than x, so a full-space sweep of failures cannot wrap it
   always_ff @(posedge clk)
      if (rst || clr) begin
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_x     <= '0;
         first_err_ya    <= '0;
         first_err_yb    <= '0;
      end else if (chk && mismatch) begin
         err_count <= err_count + 1'b1;
         if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_x     <= x;
            first_err_ya    <= y_a;
            first_err_yb    <= y_b;
         end
      end
endmodule

// File: rtl/truth_table_sweep_ctrl.sv
// truth_table_sweep_ctrl: sweeps every input vector into two implementations and checks they agree
// ports: clk/rst (sync, active-high); start begins a sweep from IDLE or DONE;
//        x drives both implementations, y_a/y_b are their outputs;
//        busy/done/pass report progress; err_count and first_err_* report failures
module truth_table_sweep_ctrl
   import tt_sweep_pkg::*;
#(
   parameter int IN_W        = DEF_IN_W,
   parameter int OUT_W       = DEF_OUT_W,
   parameter int SETTLE      = DEF_SETTLE,
   parameter int STOP_ON_ERR = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [IN_W-1:0]  x,
   input  logic [OUT_W-1:0] y_a,
   input  logic [OUT_W-1:0] y_b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [IN_W:0]    err_count,
   output logic             first_err_valid,
   output logic [IN_W-1:0]  first_err_x,
   output logic [OUT_W-1:0] first_err_ya,
   output logic [OUT_W-1:0] first_err_yb
);
   localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
   state_t state, state_nx;
   logic [SW-1:0] settle_cnt;
   logic go, settled, chk, mismatch, term;
   // start only counts when no sweep is in flight
   assign go      = start && (state == ST_IDLE || state == ST_DONE);
   assign settled = settle_cnt == SW'(SETTLE - 1);
   assign chk     = state == ST_CHECK;
   assign term    = (mismatch && STOP_ON_ERR != 0) || &x;
   tt_err_log #(.IN_W(IN_W), .OUT_W(OUT_W)) u_log (
      .clk(clk),
      .rst(rst),
      .clr(go),
      .chk(chk),
      .x(x),
      .y_a(y_a),
      .y_b(y_b),
      .mismatch(mismatch),
      .err_count(err_count),
      .first_err_valid(first_err_valid),
      .first_err_x(first_err_x),
      .first_err_ya(first_err_ya),
      .first_err_yb(first_err_yb)
   );
   always_ff @(posedge clk)
      state <= rst ? ST_IDLE : state_nx;
   always_comb
      state_nx = go                ? ST_WAIT :
                 state == ST_WAIT  ? (settled ? ST_CHECK : ST_WAIT) :
                 state == ST_CHECK ? (term ? ST_DONE : ST_WAIT) : state;
   always_comb begin
      busy = state == ST_WAIT || state == ST_CHECK;
      done = state == ST_DONE;
      pass = done && err_count == '0;
   end
   // x only moves on the CHECK edge, so it is stable for the whole settle window
   always_ff @(posedge clk)
      if (rst || go) begin
         x          <= '0;
         settle_cnt <= '0;
      end else if (state == ST_WAIT && !settled)
         settle_cnt <= settle_cnt + 1'b1;
      else if (chk && !term) begin
         x          <= x + 1'b1;
         settle_cnt <= '0;
      end
endmodule
